// File: rtl/vgaterm_engine_if.sv
// Command handshake and display-buffer write bus for vgaterm_engine.
// master = host/buffer side, slave = engine side.
interface vgaterm_engine_if #(
  parameter int unsigned ATTR_W = 25,
  parameter int unsigned ADDR_W = 12
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [7:0]        cmd_data;
  logic [ATTR_W-1:0] cmd_attr;

  logic                buf_we;
  logic [ADDR_W-1:0]   buf_addr;
  logic [8+ATTR_W-1:0] buf_wd;

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_attr,
    input  cmd_ready, buf_we, buf_addr, buf_wd
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_attr,
    output cmd_ready, buf_we, buf_addr, buf_wd
  );
endinterface

// File: rtl/vgaterm_engine.sv
// Cursor/command engine for the text terminal: writes the display buffer, scrolls via a
// circular top-row offset. Optional cursor blink generator enabled by VGATERM_BLINK_EN.
module vgaterm_engine #(
  parameter int unsigned COLS   = 80,
  parameter int unsigned ROWS   = 30,
  parameter int unsigned ATTR_W = 25
`ifdef VGATERM_BLINK_EN
  ,
  parameter int unsigned BLINK_DIV = 12_500_000
`endif
) (
  input  logic                          CLK_I,
  input  logic                          RST_N,
  vgaterm_engine_if.slave               bus,
  output logic [$clog2(ROWS)-1:0]       top_row,
  output logic [$clog2(ROWS)-1:0]       cur_row,
  output logic [$clog2(COLS)-1:0]       cur_col,
  output logic [$clog2(COLS*ROWS)-1:0]  cur_addr,
`ifdef VGATERM_BLINK_EN
  output logic                          cursor_on,
`endif
  output logic                          busy
);

  localparam int unsigned COL_W  = $clog2(COLS);
  localparam int unsigned ROW_W  = $clog2(ROWS);
  localparam int unsigned ADDR_W = $clog2(COLS*ROWS);
  localparam int unsigned WD_W   = 8 + ATTR_W;

  localparam logic [COL_W-1:0]  ColMax   = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  RowMax   = ROW_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] LineLast = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] CellLast = ADDR_W'(COLS * ROWS - 1);
  localparam logic [ADDR_W-1:0] ColsA    = ADDR_W'(COLS);
  localparam logic [7:0]        Blank    = 8'h20;

  localparam logic [2:0] OpPutc   = 3'd0;
  localparam logic [2:0] OpSetCol = 3'd1;
  localparam logic [2:0] OpSetRow = 3'd2;
  localparam logic [2:0] OpLf     = 3'd3;
  localparam logic [2:0] OpCr     = 3'd4;
  localparam logic [2:0] OpBs     = 3'd5;
  localparam logic [2:0] OpClear  = 3'd6;
  localparam logic [2:0] OpNop    = 3'd7;

  typedef enum logic [1:0] {StIdle, StClrAll, StClrLine} state_e;

  state_e            state_q, state_d;
  logic [ROW_W-1:0]  top_q, top_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ATTR_W-1:0] attr_q, attr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WD_W-1:0]   wd_q, wd_d;

  logic              accept;
  logic              do_lf;
  logic [ROW_W:0]    prow_sum;
  logic [ROW_W-1:0]  prow;
  logic [ROW_W-1:0]  top_inc;
  logic [ADDR_W-1:0] cell_addr;

  assign accept = bus.cmd_valid && bus.cmd_ready;

  // Screen row to physical row by compare-and-subtract; both operands are < ROWS.
  assign prow_sum  = {1'b0, row_q} + {1'b0, top_q};
  assign prow      = (prow_sum >= (ROW_W+1)'(ROWS)) ? ROW_W'(prow_sum - (ROW_W+1)'(ROWS))
                                                    : ROW_W'(prow_sum);
  assign top_inc   = (top_q == RowMax) ? '0 : top_q + 1'b1;
  assign cell_addr = ADDR_W'(prow) * ColsA + ADDR_W'(col_q);

  always_comb begin
    state_d = state_q;
    top_d   = top_q;
    row_d   = row_q;
    col_d   = col_q;
    attr_d  = attr_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wd_d    = wd_q;
    do_lf   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          case (bus.cmd_op)
            OpPutc: begin
              we_d   = 1'b1;
              addr_d = cell_addr;
              wd_d   = {bus.cmd_attr, bus.cmd_data};
              if (col_q == ColMax) begin
                col_d = '0;
                do_lf = 1'b1;
              end else begin
                col_d = col_q + 1'b1;
              end
            end
            OpSetCol: begin
              col_d = (32'(bus.cmd_data) >= COLS) ? ColMax : COL_W'(bus.cmd_data);
            end
            OpSetRow: begin
              row_d = (32'(bus.cmd_data) >= ROWS) ? RowMax : ROW_W'(bus.cmd_data);
            end
            OpLf: do_lf = 1'b1;
            OpCr: col_d = '0;
            OpBs: begin
              if (col_q != '0) begin
                col_d = col_q - 1'b1;
              end else if (row_q != '0) begin
                row_d = row_q - 1'b1;
                col_d = ColMax;
              end
            end
            OpClear: begin
              attr_d  = bus.cmd_attr;
              cnt_d   = '0;
              state_d = StClrAll;
            end
            OpNop: ;
            default: ;
          endcase

          if (do_lf) begin
            if (row_q != RowMax) begin
              row_d = row_q + 1'b1;
            end else begin
              // The old top row becomes the new bottom row and must be blanked.
              top_d   = top_inc;
              base_d  = ADDR_W'(top_q) * ColsA;
              attr_d  = bus.cmd_attr;
              cnt_d   = '0;
              state_d = StClrLine;
            end
          end
        end
      end

      StClrLine: begin
        we_d   = 1'b1;
        addr_d = base_q + cnt_q;
        wd_d   = {attr_q, Blank};
        if (cnt_q == LineLast) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StClrAll: begin
        we_d   = 1'b1;
        addr_d = cnt_q;
        wd_d   = {attr_q, Blank};
        if (cnt_q == CellLast) begin
          state_d = StIdle;
          top_d   = '0;
          row_d   = '0;
          col_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (!RST_N) begin
      state_q <= StIdle;
      top_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      attr_q  <= '0;
      cnt_q   <= '0;
      base_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      top_q   <= top_d;
      row_q   <= row_d;
      col_q   <= col_d;
      attr_q  <= attr_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
    end
  end

`ifdef VGATERM_BLINK_EN
  localparam int unsigned BLINK_W = $clog2(BLINK_DIV + 1);

  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_on_q, blink_on_d;
  logic               cursor_move;

  // CLEAR and NOP leave the blink phase alone; every cursor-affecting command restarts it.
  assign cursor_move = accept && (bus.cmd_op != OpClear) && (bus.cmd_op != OpNop);

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    if (cursor_move) begin
      blink_cnt_d = '0;
      blink_on_d  = 1'b1;
    end else if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt_d = '0;
      blink_on_d  = ~blink_on_q;
    end else begin
      blink_cnt_d = blink_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (!RST_N) begin
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
    end
  end

  assign cursor_on = blink_on_q;
`endif

  assign bus.cmd_ready = (state_q == StIdle) && RST_N;
  assign bus.buf_we    = we_q;
  assign bus.buf_addr  = addr_q;
  assign bus.buf_wd    = wd_q;
  assign top_row       = top_q;
  assign cur_row       = row_q;
  assign cur_col       = col_q;
  assign cur_addr      = cell_addr;
  assign busy          = (state_q != StIdle);

endmodule
